router_fifo_pkt: RTL and testbench
==================================

Name: router_fifo_pkt

Overview:
Parametrised successor of the router output FIFO: one per output channel of the 1x3 router, sitting between the router FSM/register stage and the destination read port.
- Stores each word with its lfd (header) tag.
- Decodes the payload length from each header as it is read out, to delimit packets.
- Reports occupancy, almost-full and the number of packets held.
- Optionally checks the trailing parity byte.

Parameters:
DATA_WIDTH, 8, word width; header layout is {payload_len[DATA_WIDTH-1:2], addr[1:0]}
DEPTH, 16, number of entries; power of two, >=4
AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN
CW, $clog2(DEPTH+1), width of count outputs (localparam)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous flush, active high
write_enb  in  1  write request
read_enb  in  1  read request
lfd_state  in  1  current data_in word is a header
data_in  in  DATA_WIDTH  write data
data_out  out  DATA_WIDTH  registered read data
out_valid  out  1  data_out updated this cycle
full  out  1  count==DEPTH
empty  out  1  count==0
almost_full  out  1  count>=DEPTH-AF_MARGIN
count  out  CW  entries held
pkt_count  out  CW  lfd-tagged entries held
pkt_done  out  1  1-cycle pulse when the last word of a packet (parity) is output
err  out  1  1-cycle parity-mismatch pulse (0 when feature off)

Behaviour:
Reset (resetn=0, async): clear all state. Output reset values:
- data_out=0, out_valid=0, full=0, empty=1, almost_full=0, count=0, pkt_count=0, pkt_done=0, err=0.
- Pointers and byte counter=0.
- Memory contents are don't-care.

Storage and handshake:
- Storage: DEPTH x (DATA_WIDTH+1); bit DATA_WIDTH holds lfd_state.
- Write is accepted iff write_enb && !full, judged on pre-edge state. A write while full is ignored even if a read occurs in the same cycle.
- Read is accepted iff read_enb && !empty. A read while empty is ignored; a same-cycle write is still accepted.
- Simultaneous accepted read and write: count unchanged; pointers both advance, wrapping at DEPTH.

Outputs:
- Read latency 1: data_out and out_valid=1 update on the clock edge of the accepted read. With no read, data_out holds its value and out_valid=0.
- full, empty, almost_full and count are registered and consistent with count after each edge.
- pkt_count: +1 on an accepted write with lfd_state=1; -1 on an accepted read of a tagged entry; both in the same cycle leaves it unchanged.

Packet tracking:
- Byte counter, DATA_WIDTH-1 bits.
- Reading a tagged entry loads counter = payload_len+1 (payload plus parity).
- Each subsequent accepted read decrements the counter.
- When the read brings the counter from 1 to 0, pkt_done pulses, coincident with out_valid.
- payload_len=0: the next read is the parity word and pkt_done pulses on it.
- A tagged entry read while counter!=0 (truncated packet) reloads the counter; no pkt_done is generated for the truncated packet.

soft_reset (sync, highest priority after resetn):
- Next edge: pointers, count, pkt_count and counter go to 0; data_out=0; out_valid, pkt_done and err are 0.
- Same-cycle write and read are discarded.
- Asserting it mid-packet abandons the packet.

Optional Feature:
ROUTER_FIFO_PARITY_CHK_EN
- Defined:
  - A DATA_WIDTH XOR accumulator is loaded with the header on a header read and XORs each payload word read.
  - On the parity-word read, err pulses with pkt_done if the parity word != accumulator.
  - The accumulator clears on resetn and on soft_reset.
- Undefined: no accumulator logic; err is tied to 0.

Test Plan:
1. Reset check: resetn low for 2 cycles, then high -> empty=1, full=0, count=0, data_out=8'h00, pkt_done=0.
2. Fill: write header 8'h38 (len 14, addr 0, lfd=1), 14 random payloads, then parity (16 writes) -> full=1, almost_full=1 from count=14, count=16, pkt_count=1. A 17th write is ignored; count stays 16.
3. Drain: read_enb=1 for 16 cycles -> data_out follows the written order, 1 cycle after each read. pkt_done pulses only on the 16th read; then empty=1, pkt_count=0. Extra reads leave out_valid=0.
4. Concurrent: at count=5, write_enb=read_enb=1 for 3 cycles -> count stays 5, FIFO order is preserved across pointer wrap. With full=1, write+read gives count 15.
5. Soft reset mid-packet: after 6 writes and 2 reads, pulse soft_reset -> next edge: count=0, empty=1, pkt_count=0, data_out=0. A new packet of header 8'h04 (len 1) plus 2 words then reads out cleanly, with pkt_done on word 3.
6. With ROUTER_FIFO_PARITY_CHK_EN: packet header 8'h08 (len 2), payloads 8'h11 and 8'h22, parity 8'h3B -> err=0. The same packet with parity 8'h3A -> err=1 in the same cycle as pkt_done.

Source files
------------

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: tagged storage, registered read (latency 1), packet delimiting.
// Optional trailing parity check enabled by ROUTER_FIFO_PARITY_CHK_EN.
module router_fifo_pkt #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         pkt_count,
  output logic                  pkt_done,
  output logic                  err
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = DATA_WIDTH - 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [BW-1:0]         byte_cnt;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH:0]   rd_word;
  logic                  rd_tag;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic [BW-1:0]         hdr_len;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         pkt_nxt;

  // Acceptance is judged on the registered flags, so a full FIFO ignores writes even with a concurrent read.
  assign wr_ok   = write_enb && !full;
  assign rd_ok   = read_enb && !empty;
  assign rd_word = mem[rd_ptr];
  assign rd_tag  = rd_word[DATA_WIDTH];
  assign rd_dat  = rd_word[DATA_WIDTH-1:0];
  assign hdr_len = {1'b0, rd_dat[DATA_WIDTH-1:2]} + BW'(1);

  always_comb begin
    count_nxt = count;
    pkt_nxt   = pkt_count;
    if (wr_ok && !rd_ok) count_nxt = count + CW'(1);
    if (rd_ok && !wr_ok) count_nxt = count - CW'(1);
    if ((wr_ok && lfd_state) && !(rd_ok && rd_tag)) pkt_nxt = pkt_count + CW'(1);
    if ((rd_ok && rd_tag) && !(wr_ok && lfd_state)) pkt_nxt = pkt_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !soft_reset) mem[wr_ptr] <= {lfd_state, data_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pkt_count   <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      byte_cnt    <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      pkt_done    <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pkt_count   <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      byte_cnt    <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      count       <= count_nxt;
      pkt_count   <= pkt_nxt;
      full        <= (count_nxt == FULL_LVL);
      empty       <= (count_nxt == '0);
      almost_full <= (count_nxt >= AF_LVL);
      out_valid   <= rd_ok;
      pkt_done    <= 1'b0;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= rd_dat;
        // A header always restarts delimiting, silently abandoning any truncated packet.
        if (rd_tag) begin
          byte_cnt <= hdr_len;
        end else if (byte_cnt != '0) begin
          byte_cnt <= byte_cnt - BW'(1);
          pkt_done <= (byte_cnt == BW'(1));
        end
      end
    end
  end

`ifdef ROUTER_FIFO_PARITY_CHK_EN
  logic [DATA_WIDTH-1:0] acc;

  // Parity word is expected to equal header XOR all payload words.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      err <= 1'b0;
    end else if (soft_reset) begin
      acc <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (rd_ok) begin
        if (rd_tag) begin
          acc <= rd_dat;
        end else if (byte_cnt == BW'(1)) begin
          err <= (rd_dat != acc);
        end else if (byte_cnt != '0) begin
          acc <= acc ^ rd_dat;
        end
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Bench for router_fifo_pkt: directed and random traffic against a queue-based packet model.
module tb_router_fifo_pkt;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          soft_reset;
  logic          write_enb;
  logic          read_enb;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_count;
  logic          pkt_done;
  logic          err;

  router_fifo_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk(clk), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .pkt_count(pkt_count), .pkt_done(pkt_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO contents as a queue of {tag, word}; packet progress as words still owed.
  logic [DW:0]   q[$];
  logic [DW-1:0] e_dout;
  logic          e_ov, e_done, e_err;
  int            rem;
  logic [DW-1:0] par;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tagged_in_q();
    int n = 0;
    foreach (q[i]) if (q[i][DW]) n++;
    return n;
  endfunction

  task automatic chk_all(input string ctx);
    chk({ctx, ".data_out"}, 32'(data_out), 32'(e_dout));
    chk({ctx, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({ctx, ".count"}, 32'(count), q.size());
    chk({ctx, ".pkt_count"}, 32'(pkt_count), tagged_in_q());
    chk({ctx, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({ctx, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({ctx, ".almost_full"}, 32'(almost_full), 32'(q.size() >= DEPTH - AFM));
    chk({ctx, ".pkt_done"}, 32'(pkt_done), 32'(e_done));
    chk({ctx, ".err"}, 32'(err), 32'(e_err));
  endtask

  task automatic model_clear();
    q.delete();
    e_dout = '0; e_ov = 1'b0; e_done = 1'b0; e_err = 1'b0;
    rem = 0; par = '0;
  endtask

  task automatic cyc(input string ctx, input logic we, input logic re, input logic lfd,
                     input logic [DW-1:0] din, input logic sr);
    logic        wr, rd;
    logic [DW:0] w;
    write_enb = we; read_enb = re; lfd_state = lfd; data_in = din; soft_reset = sr;
    wr = we && (q.size() < DEPTH);
    rd = re && (q.size() > 0);
    @(posedge clk);
    if (sr) begin
      model_clear();
    end else begin
      e_ov = rd; e_done = 1'b0; e_err = 1'b0;
      if (rd) begin
        w = q.pop_front();
        e_dout = w[DW-1:0];
        if (w[DW]) begin
          rem = int'(w[DW-1:2]) + 1;
          par = w[DW-1:0];
        end else if (rem > 0) begin
          if (rem == 1) begin
            e_done = 1'b1;
`ifdef ROUTER_FIFO_PARITY_CHK_EN
            e_err = (w[DW-1:0] != par);
`endif
          end else begin
            par = par ^ w[DW-1:0];
          end
          rem--;
        end
      end
      if (wr) q.push_back({lfd, din});
    end
    #1;
    chk_all(ctx);
  endtask

  task automatic idle(input string ctx);
    cyc(ctx, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] p;
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 chk_all("reset");
    resetn = 1'b1;
    idle("post_reset");

    // Fill: header len 14, 14 payloads, parity, then one ignored write.
    p = 8'h38;
    cyc("fill_hdr", 1'b1, 1'b0, 1'b1, 8'h38, 1'b0);
    for (int i = 0; i < 14; i++) begin
      d = DW'($urandom);
      p = p ^ d;
      cyc("fill_pl", 1'b1, 1'b0, 1'b0, d, 1'b0);
    end
    cyc("fill_par", 1'b1, 1'b0, 1'b0, p, 1'b0);
    cyc("fill_over", 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);

    // Drain plus two reads on empty.
    for (int i = 0; i < 18; i++) cyc("drain", 1'b0, 1'b1, 1'b0, '0, 1'b0);

    // Concurrent read/write at count 5, then at full.
    cyc("conc_hdr", 1'b1, 1'b0, 1'b1, 8'h0C, 1'b0);
    for (int i = 0; i < 4; i++) cyc("conc_w", 1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) cyc("conc_rw", 1'b1, 1'b1, 1'b0, DW'($urandom), 1'b0);
    while (q.size() < DEPTH) cyc("conc_fill", 1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0);
    cyc("full_rw", 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc("conc_drain", 1'b0, 1'b1, 1'b0, '0, 1'b0);

    // Soft reset mid-packet, with a discarded same-cycle write and read.
    cyc("sr_hdr", 1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 5; i++) cyc("sr_w", 1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0);
    for (int i = 0; i < 2; i++) cyc("sr_r", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    cyc("soft_reset", 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    cyc("sr_new_hdr", 1'b1, 1'b0, 1'b1, 8'h04, 1'b0);
    cyc("sr_new_pl", 1'b1, 1'b0, 1'b0, 8'h77, 1'b0);
    cyc("sr_new_par", 1'b1, 1'b0, 1'b0, 8'h04 ^ 8'h77, 1'b0);
    for (int i = 0; i < 4; i++) cyc("sr_new_rd", 1'b0, 1'b1, 1'b0, '0, 1'b0);

`ifdef ROUTER_FIFO_PARITY_CHK_EN
    for (int k = 0; k < 2; k++) begin
      cyc("par_hdr", 1'b1, 1'b0, 1'b1, 8'h08, 1'b0);
      cyc("par_p0", 1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
      cyc("par_p1", 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
      cyc("par_w", 1'b1, 1'b0, 1'b0, (k == 0) ? 8'h3B : 8'h3A, 1'b0);
      for (int i = 0; i < 4; i++) cyc("par_rd", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    end
`endif

    // Random traffic: short packets, occasional truncation and soft reset.
    for (int i = 0; i < 400; i++) begin
      logic lfd;
      lfd = ($urandom_range(0, 3) == 0);
      d = lfd ? {6'($urandom_range(0, 4)), 2'($urandom)} : DW'($urandom);
      cyc("rand", 1'($urandom), 1'($urandom_range(0, 2) != 0), lfd, d,
          ($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset mid-cycle while non-empty.
    for (int i = 0; i < 3; i++) cyc("pre_arst", 1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0);
    cyc("pre_arst_rd", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    model_clear();
    chk_all("async_reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    idle("after_arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
